// File: rtl/uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_oversampled
// Description : Oversampling UART receiver. The serial line is synchronized,
//               the start bit is qualified at its midpoint, and every data and
//               stop bit is sampled once at mid-bit by counting baud ticks.
//               Data is received LSB-first.
// Ports       : CLK          - system clock, rising edge
//               RESET        - synchronous active-high reset
//               s_tick       - baud enable, NUM_TICKS pulses per bit period
//               rx_bit       - asynchronous serial input, idle high
//               data_out     - last correctly received word
//               rx_done_tick - one-cycle pulse when data_out was just updated
//               frame_error  - one-cycle pulse when the stop bit sampled low
// Parameters  : NBIT_DATA in 5..9, NUM_TICKS even and >= 8
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_oversampled #(
  parameter int NBIT_DATA = 8,
  parameter int NUM_TICKS = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 s_tick,
  input  logic                 rx_bit,
  output logic [NBIT_DATA-1:0] data_out,
  output logic                 rx_done_tick,
  output logic                 frame_error
);

  localparam int c_SW = $clog2(NUM_TICKS);
  localparam int c_NW = $clog2(NBIT_DATA);

  localparam logic [c_SW-1:0] c_S_MID  = c_SW'(NUM_TICKS / 2 - 1);
  localparam logic [c_SW-1:0] c_S_LAST = c_SW'(NUM_TICKS - 1);
  localparam logic [c_NW-1:0] c_N_LAST = c_NW'(NBIT_DATA - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_START = 2'd1;
  localparam logic [1:0] c_DATA  = 2'd2;
  localparam logic [1:0] c_STOP  = 2'd3;

  logic                 r_sync1;
  logic                 r_sync2;
  logic [1:0]           r_state;
  logic [c_SW-1:0]      r_s_cnt;
  logic [c_NW-1:0]      r_n_cnt;
  logic [NBIT_DATA-1:0] r_shift;
  logic [NBIT_DATA-1:0] r_data;
  logic                 r_done;
  logic                 r_ferr;

  logic                 w_rx_s;
  logic [1:0]           w_state_next;
  logic [c_SW-1:0]      w_s_cnt_next;
  logic [c_NW-1:0]      w_n_cnt_next;
  logic [NBIT_DATA-1:0] w_shift_next;
  logic                 w_stop_sample;
  logic                 w_done_set;
  logic                 w_ferr_set;

  assign w_rx_s = r_sync2;

  // State register, counters, shift register, synchronizer and the
  // registered result outputs. Synchronizer resets high so that reset
  // release never looks like a falling edge on an idle line.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= c_IDLE;
      r_s_cnt <= '0;
      r_n_cnt <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync1 <= rx_bit;
      r_sync2 <= r_sync1;
      r_state <= w_state_next;
      r_s_cnt <= w_s_cnt_next;
      r_n_cnt <= w_n_cnt_next;
      r_shift <= w_shift_next;
      r_done  <= w_done_set;
      r_ferr  <= w_ferr_set;
      if (w_done_set) begin
        r_data <= r_shift;
      end
    end
  end

  // Next-state logic. Only the IDLE start detection runs without a tick.
  always_comb begin
    w_state_next = r_state;
    w_s_cnt_next = r_s_cnt;
    w_n_cnt_next = r_n_cnt;
    w_shift_next = r_shift;
    case (r_state)
      c_IDLE: begin
        if (!w_rx_s) begin
          w_state_next = c_START;
          w_s_cnt_next = '0;
        end
      end
      c_START: begin
        if (s_tick) begin
          if (r_s_cnt == c_S_MID) begin
            // A line that is high again at mid start bit was a glitch.
            if (!w_rx_s) begin
              w_state_next = c_DATA;
              w_s_cnt_next = '0;
              w_n_cnt_next = '0;
            end else begin
              w_state_next = c_IDLE;
            end
          end else begin
            w_s_cnt_next = r_s_cnt + 1'b1;
          end
        end
      end
      c_DATA: begin
        if (s_tick) begin
          if (r_s_cnt == c_S_LAST) begin
            w_s_cnt_next = '0;
            w_n_cnt_next = r_n_cnt + 1'b1;
            w_shift_next = {w_rx_s, r_shift[NBIT_DATA-1:1]};
            if (r_n_cnt == c_N_LAST) begin
              w_state_next = c_STOP;
            end
          end else begin
            w_s_cnt_next = r_s_cnt + 1'b1;
          end
        end
      end
      c_STOP: begin
        if (s_tick) begin
          if (r_s_cnt == c_S_LAST) begin
            w_state_next = c_IDLE;
          end else begin
            w_s_cnt_next = r_s_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = c_IDLE;
      end
    endcase
  end

  // Output decode: the stop-bit sample decides between done and error.
  // Both results are registered, so the pulses appear one cycle later.
  always_comb begin
    w_stop_sample = (r_state == c_STOP) && s_tick && (r_s_cnt == c_S_LAST);
    w_done_set    = w_stop_sample && w_rx_s;
    w_ferr_set    = w_stop_sample && !w_rx_s;
  end

  assign data_out     = r_data;
  assign rx_done_tick = r_done;
  assign frame_error  = r_ferr;

endmodule
`default_nettype wire

// File: doc/uart_rx_oversampled.md
UART_RX_OVERSAMPLED -- requirements
Module: uart_rx_oversampled

Interface
REQ-001 Parameter NBIT_DATA, default 8, data bits per frame, SHALL be in the range 5..9.
REQ-002 Parameter NUM_TICKS, default 16, oversampling ticks per bit, SHALL be an even value of at least 8.
REQ-003 CLK  input  1  system clock; all state SHALL update on the rising edge only.
REQ-004 RESET  input  1  reset, synchronous and active-high, sampled on the rising edge of CLK.
REQ-005 s_tick  input  1  baud-rate enable from the baud generator, one CLK cycle wide, NUM_TICKS pulses per bit period.
REQ-006 rx_bit  input  1  asynchronous serial line; idle level is high.
REQ-007 data_out  output  NBIT_DATA  last correctly received byte.
REQ-008 rx_done_tick  output  1  one-cycle pulse when data_out has just been updated.
REQ-009 frame_error  output  1  one-cycle pulse when the stop bit is sampled low.

Function
REQ-010 rx_bit SHALL pass through a 2-flop synchronizer, and all logic SHALL use the synchronized value rx_s.
REQ-011 The FSM SHALL have four states, IDLE, START, DATA and STOP, plus a tick counter s_cnt and a bit counter n_cnt.
REQ-012 In IDLE, rx_s==0 SHALL cause a move to START with s_cnt cleared; s_tick is not required for this transition.
REQ-013 In START, each s_tick SHALL increment s_cnt.
REQ-014 In START, at s_tick with s_cnt==NUM_TICKS/2-1 (mid start bit):
- rx_s==0: move to DATA, clear s_cnt and n_cnt.
- rx_s==1: return to IDLE as a glitch, with no output activity.
REQ-015 In DATA, at s_tick with s_cnt==NUM_TICKS-1:
- shift rx_s into the MSB of the shift register, so bits are received LSB-first;
- clear s_cnt and increment n_cnt;
- if n_cnt==NBIT_DATA-1, move to STOP.
REQ-016 In STOP, at s_tick with s_cnt==NUM_TICKS-1:
- rx_s==1: load data_out from the shift register, pulse rx_done_tick in the following cycle, go to IDLE.
- rx_s==0: pulse frame_error in the following cycle, leave data_out unchanged, go to IDLE.
REQ-017 Cycles without s_tick SHALL hold all counters and the state, except for the IDLE start detection.
REQ-018 rx_done_tick and frame_error SHALL never both be high in the same cycle, and each SHALL be high for exactly one CLK cycle per frame.
REQ-019 A new start bit that follows the stop-bit sample SHALL be accepted immediately from IDLE, so that back-to-back frames with no idle gap are received.
REQ-020 data_out SHALL be held stable between rx_done_tick pulses.
REQ-021 The block SHALL have no input-to-output combinational path.

Reset
REQ-022 While RESET=1:
- state SHALL be IDLE;
- s_cnt, n_cnt and the shift register SHALL be 0;
- both synchronizer flops SHALL be 1;
- data_out SHALL be 0;
- rx_done_tick and frame_error SHALL be 0.
REQ-023 RESET asserted mid-frame SHALL abort the frame with no pulse and no data_out update, and the next falling edge after RESET is released SHALL start a fresh frame.
REQ-024 RESET SHALL take priority over s_tick and over rx_bit activity.

Verification
REQ-025 The bench SHALL cover the following directed scenarios (NUM_TICKS=16, s_tick every 4 CLKs, NBIT_DATA=8):
- Frame 0x5A with a stop bit of 1 -> a single rx_done_tick pulse, data_out=0x5A, frame_error never asserted.
- Frames 0xFF and 0x00 back-to-back with no idle gap -> two rx_done_tick pulses, with data_out=0xFF and then 0x00.
- rx_bit low for 5 s_ticks and then high -> return to IDLE with no pulses, data_out unchanged.
- Frame 0xA5 with the stop bit held low -> a single frame_error pulse, no rx_done_tick, data_out keeps its previous value.
- RESET pulsed during data bit 3 of frame 0x3C, followed by a clean frame 0xC3 -> no pulse for 0x3C, rx_done_tick with data_out=0xC3.
- Frame 0x81 with rx_bit toggled only between sample points -> data_out=0x81, showing that sampling occurs only at mid-bit.
